// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM read-return burst FIFO controller.
package sdram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2
  } fill_st_e;

  localparam int BURST_DEF = 4;

endpackage

// File: rtl/sdram_fifo_skid.sv
// Two-entry output skid buffer: absorbs RAM read data that is already in
// flight when the consumer stalls.
module sdram_fifo_skid #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic [1:0]       o_occ
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_occ;
  logic             w_pop;

  assign w_pop  = i_pop && (r_occ != 2'd0);
  assign o_dout = r_head;
  assign o_occ  = r_occ;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= 2'd0;
    end else if (i_clear) begin
      r_occ <= 2'd0;
    end else begin
      case ({i_load, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_head <= i_din;
          else               r_tail <= i_din;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; the new word lands behind whatever remains
          if (r_occ == 2'd1) begin
            r_head <= i_din;
          end else begin
            r_head <= r_tail;
            r_tail <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sdram_burst_fifo_ctrl.sv
// Burst FIFO controller: requests SDRAM bursts only when a whole burst fits,
// writes returned words via RAM port A, streams them out via port B + skid.
module sdram_burst_fifo_ctrl
  import sdram_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int BURST = BURST_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  output logic             fill_req,
  input  logic             fill_ack,
  input  logic             fill_valid,
  input  logic [WIDTH-1:0] fill_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [DEPTH:0]   level,
  output logic             ram_wren_a,
  output logic [DEPTH-1:0] ram_address_a,
  output logic [WIDTH-1:0] ram_data_a,
  output logic             ram_wren_b,
  output logic [DEPTH-1:0] ram_address_b,
  input  logic [WIDTH-1:0] ram_q_b
);

  localparam int              CNT_W = $clog2(BURST) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST - 1);
  localparam logic [DEPTH+1:0] CAP  = (DEPTH+2)'(1 << DEPTH);
  localparam logic [DEPTH+1:0] BLEN = (DEPTH+2)'(BURST);

  fill_st_e         r_state;
  logic             r_fill_req;
  logic [CNT_W-1:0] r_cnt;
  logic             r_discard;
  logic [DEPTH:0]   r_wptr;
  logic [DEPTH:0]   r_rptr;
  logic             r_inflight;
  logic [DEPTH:0]   r_level;

  logic [DEPTH:0]   w_owed;
  logic [DEPTH:0]   w_resv;
  logic [DEPTH:0]   w_used;
  logic             w_room;
  logic             w_beat;
  logic             w_wr;
  logic             w_rd;
  logic             w_pop;
  logic [1:0]       w_occ;

  // Words still owed by an undiscarded burst count against free space.
  always_comb begin
    w_owed = '0;
    if (!r_discard) begin
      case (r_state)
        ST_REQ:  w_owed = (DEPTH+1)'(BURST);
        ST_FILL: w_owed = (DEPTH+1)'(BURST) - (DEPTH+1)'(r_cnt);
        default: w_owed = '0;
      endcase
    end
  end

  assign w_resv = r_wptr + w_owed;
  assign w_used = w_resv - r_rptr;
  assign w_room = ({1'b0, w_used} + BLEN) <= CAP;

  // A data beat can coincide with the ack that opens the burst.
  assign w_beat = fill_valid &&
                  ((r_state == ST_FILL) || ((r_state == ST_REQ) && fill_ack));
  assign w_wr   = w_beat && !(r_discard || flush);

  assign w_pop    = rd_valid && rd_ready;
  assign rd_valid = (w_occ != 2'd0);
  // Reads stay ahead of the consumer without ever overrunning the skid.
  assign w_rd = !flush && (r_rptr != r_wptr) &&
                (({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));

  assign fill_req      = r_fill_req;
  assign level         = r_level;
  assign ram_wren_a    = w_wr;
  assign ram_address_a = r_wptr[DEPTH-1:0];
  assign ram_data_a    = fill_data;
  assign ram_wren_b    = 1'b0;
  assign ram_address_b = r_rptr[DEPTH-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_fill_req <= 1'b0;
      r_cnt      <= '0;
      r_discard  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!flush && w_room) begin
            r_state    <= ST_REQ;
            r_fill_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (flush) r_discard <= 1'b1;
          if (fill_ack) begin
            r_fill_req <= 1'b0;
            if (fill_valid && (BURST == 1)) begin
              r_state   <= ST_IDLE;
              r_cnt     <= '0;
              r_discard <= 1'b0;
            end else begin
              r_state <= ST_FILL;
              r_cnt   <= fill_valid ? CNT_W'(1) : '0;
            end
          end
        end
        ST_FILL: begin
          if (flush) r_discard <= 1'b1;
          if (fill_valid) begin
            if (r_cnt == LAST) begin
              r_state   <= ST_IDLE;
              r_cnt     <= '0;
              r_discard <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_fill_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_inflight <= 1'b0;
      r_level    <= '0;
    end else if (flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_inflight <= 1'b0;
      r_level    <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + (DEPTH+1)'(1);
      if (w_rd) r_rptr <= r_rptr + (DEPTH+1)'(1);
      r_inflight <= w_rd;
      r_level    <= r_level + (DEPTH+1)'(w_wr) - (DEPTH+1)'(w_pop);
    end
  end

  sdram_fifo_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clock   (clock),
    .reset_n (reset_n),
    .i_clear (flush),
    .i_load  (r_inflight),
    .i_din   (ram_q_b),
    .i_pop   (w_pop),
    .o_dout  (rd_data),
    .o_occ   (w_occ)
  );

endmodule

// File: tb/tb_sdram_burst_fifo_ctrl.sv
// Scoreboard bench: burst drivers queue expected words, a negedge monitor
// checks every presented word against the queue head.
module tb_sdram_burst_fifo_ctrl;

  localparam int DEPTH = 3;
  localparam int WIDTH = 32;
  localparam int BURST = 4;

  logic             clock      = 1'b0;
  logic             reset_n    = 1'b0;
  logic             flush      = 1'b0;
  logic             fill_ack   = 1'b0;
  logic             fill_valid = 1'b0;
  logic [WIDTH-1:0] fill_data  = '0;
  logic             rd_ready   = 1'b0;
  logic             fill_req;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic [DEPTH:0]   level;
  logic             ram_wren_a;
  logic [DEPTH-1:0] ram_address_a;
  logic [WIDTH-1:0] ram_data_a;
  logic             ram_wren_b;
  logic [DEPTH-1:0] ram_address_b;
  logic [WIDTH-1:0] ram_q_b;

  logic [WIDTH-1:0] mem [2**DEPTH];
  logic [WIDTH-1:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
    ram_q_b <= mem[ram_address_b];
  end

  sdram_burst_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .fill_req(fill_req), .fill_ack(fill_ack), .fill_valid(fill_valid),
    .fill_data(fill_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .level(level), .ram_wren_a(ram_wren_a),
    .ram_address_a(ram_address_a), .ram_data_a(ram_data_a),
    .ram_wren_b(ram_wren_b), .ram_address_b(ram_address_b), .ram_q_b(ram_q_b)
  );

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every presented word must match the queue head; handshakes pop it.
  always @(negedge clock) begin
    if (reset_n && rd_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_unexpected: got %0h, expected no word", rd_data);
      end else begin
        if (rd_data !== exp_q[0]) begin
          n_err++;
          $display("FAIL rd_data: got %0h, expected %0h", rd_data, exp_q[0]);
        end
        if (rd_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_req(input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (fill_req) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    chk("fill_req_wait", {31'b0, seen}, 32'd1);
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clock);
    end
    chk("drain", exp_q.size(), 32'd0);
    @(posedge clock);
    @(negedge clock);
    chk("level_drained", level, 32'd0);
  endtask

  task automatic drive_burst(input logic [WIDTH-1:0] base, input bit push);
    wait_req(40);
    @(posedge clock); #1;
    fill_ack   = 1'b1;
    fill_valid = 1'b1;
    for (int i = 0; i < BURST; i++) begin
      if (i > 0) begin
        @(posedge clock); #1;
        fill_ack = 1'b0;
      end
      fill_data = base + WIDTH'(i);
      if (push) exp_q.push_back(base + WIDTH'(i));
    end
    @(posedge clock); #1;
    fill_valid = 1'b0;
    fill_data  = '0;
  endtask

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_fill_req", fill_req, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_wren_a", ram_wren_a, 0);
    chk("rst_wren_b", ram_wren_b, 0);
    reset_n = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("req_after_reset", fill_req, 1);
    chk("idle_rd_valid", rd_valid, 0);
    chk("idle_level", level, 0);

    // Latency and streaming: first word visible 3 cycles after it arrives.
    @(posedge clock); #1;
    rd_ready = 1'b1;
    fork
      drive_burst(32'hA0, 1'b1);
      begin
        @(posedge clock);
        repeat (3) begin
          @(negedge clock);
          chk("lat_rd_valid_lo", rd_valid, 0);
        end
        repeat (4) begin
          @(negedge clock);
          chk("stream_rd_valid", rd_valid, 1);
        end
      end
    join
    wait_drain(20);

    // Two bursts with a stalled consumer fill RAM + skid; drain across wrap.
    @(posedge clock); #1;
    rd_ready = 1'b0;
    drive_burst(32'hB0, 1'b1);
    drive_burst(32'hC0, 1'b1);
    repeat (6) @(negedge clock);
    chk("full_level", level, 8);
    chk("full_no_req", fill_req, 0);
    repeat (3) @(negedge clock);
    chk("full_no_req_hold", fill_req, 0);
    chk("full_rd_valid", rd_valid, 1);
    @(posedge clock); #1;
    rd_ready = 1'b1;
    wait_req(20);
    wait_drain(40);

    // Toggling ready: no loss, no duplication, data held while stalled.
    fork
      drive_burst(32'hD0, 1'b1);
      begin
        repeat (16) begin
          @(posedge clock); #1;
          rd_ready = ~rd_ready;
        end
      end
    join
    @(posedge clock); #1;
    rd_ready = 1'b1;
    wait_drain(30);

    // Flush after the second word of a burst; rest of burst is discarded.
    wait_req(20);
    @(posedge clock); #1;
    rd_ready   = 1'b0;
    fill_ack   = 1'b1;
    fill_valid = 1'b1;
    fill_data  = 32'hE0;
    @(posedge clock); #1;
    fill_ack  = 1'b0;
    fill_data = 32'hE1;
    @(posedge clock); #1;
    fill_valid = 1'b0;
    fill_data  = '0;
    flush      = 1'b1;
    @(negedge clock);
    chk("pre_flush_level", level, 2);
    @(posedge clock); #1;
    flush      = 1'b0;
    fill_valid = 1'b1;
    fill_data  = 32'hE2;
    @(negedge clock);
    chk("flush_level", level, 0);
    chk("flush_rd_valid", rd_valid, 0);
    @(posedge clock); #1;
    fill_data = 32'hE3;
    @(posedge clock); #1;
    fill_valid = 1'b0;
    fill_data  = '0;
    repeat (3) @(negedge clock);
    chk("discard_level", level, 0);
    chk("discard_rd_valid", rd_valid, 0);
    @(posedge clock); #1;
    rd_ready = 1'b1;
    drive_burst(32'hF0, 1'b1);
    wait_drain(20);

    // Asynchronous reset in the middle of a burst.
    wait_req(20);
    @(posedge clock); #1;
    rd_ready   = 1'b0;
    fill_ack   = 1'b1;
    fill_valid = 1'b1;
    fill_data  = 32'h10;
    @(posedge clock); #1;
    fill_ack  = 1'b0;
    fill_data = 32'h11;
    @(posedge clock); #1;
    fill_data = 32'h12;
    #1;
    chk("pre_rst_wren_a", ram_wren_a, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_fill_req", fill_req, 0);
    chk("arst_rd_valid", rd_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_rd_data", rd_data, 0);
    chk("arst_wren_a", ram_wren_a, 0);
    fill_valid = 1'b0;
    fill_data  = '0;
    @(posedge clock); #1;
    reset_n  = 1'b1;
    rd_ready = 1'b1;
    drive_burst(32'h20, 1'b1);
    wait_drain(20);

    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
